// File: rtl/m31_pkg.sv
// Shared M31 field definitions: modulus, element type, canonicalisation and loader states.
package m31_pkg;

  localparam int unsigned M31_WIDTH = 31;
  localparam logic [30:0] M31_P     = 31'h7FFF_FFFF;

  typedef logic [30:0] m31_t;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    FULL
  } loader_state_t;

  // p itself is congruent to 0; nothing else is reduced.
  function automatic m31_t m31_canon(input m31_t x);
    return (x == M31_P) ? '0 : x;
  endfunction

endpackage

// File: rtl/m31_vector_operand_loader.sv
// Serial-to-parallel loader: assembles vec1 then vec2 from a valid/ready word stream
// and holds the canonicalised pair with out_valid until the adder accepts it.
module m31_vector_operand_loader
  import m31_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = 31,
  parameter int unsigned VECTOR_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic [WORD_WIDTH-1:0] vec1 [0:VECTOR_SIZE-1],
  output logic [WORD_WIDTH-1:0] vec2 [0:VECTOR_SIZE-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  framing_err
);

  localparam int unsigned IDXW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(VECTOR_SIZE - 1);

  loader_state_t   state, state_nxt;
  logic [IDXW-1:0] idx, idx_nxt;
  logic            ferr_nxt;
  logic            wr_a, wr_b;
  logic            in_fire, out_fire, idx_last;

  assign in_fire  = s_valid & s_ready;
  assign out_fire = out_valid & out_ready;
  assign idx_last = (idx == IDX_LAST);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ferr_nxt  = framing_err;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    if (clear) begin
      state_nxt = LOAD_A;
      idx_nxt   = '0;
      ferr_nxt  = 1'b0;
    end else begin
      unique case (state)
        LOAD_A: if (in_fire) begin
          wr_a = 1'b1;
          if (s_last) ferr_nxt = 1'b1;
          if (idx_last) begin
            idx_nxt   = '0;
            state_nxt = LOAD_B;
          end else begin
            idx_nxt = idx + IDXW'(1);
          end
        end
        LOAD_B: if (in_fire) begin
          wr_b = 1'b1;
          if (s_last != idx_last) ferr_nxt = 1'b1;
          if (idx_last) begin
            idx_nxt   = '0;
            state_nxt = FULL;
          end else begin
            idx_nxt = idx + IDXW'(1);
          end
        end
        FULL: if (out_fire) begin
          idx_nxt   = '0;
          state_nxt = LOAD_A;
        end
        default: begin
          idx_nxt   = '0;
          state_nxt = LOAD_A;
        end
      endcase
    end
  end

  // Handshake flags are flopped from the next state so they never depend on s_valid/out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD_A;
      idx         <= '0;
      framing_err <= 1'b0;
      s_ready     <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      framing_err <= ferr_nxt;
      s_ready     <= (state_nxt != FULL);
      out_valid   <= (state_nxt == FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < VECTOR_SIZE; i++) begin
        vec1[i] <= '0;
        vec2[i] <= '0;
      end
    end else begin
      if (wr_a) vec1[idx] <= m31_canon(s_data);
      if (wr_b) vec2[idx] <= m31_canon(s_data);
    end
  end

endmodule

// File: tb/tb_m31_vector_operand_loader.sv
// Randomised and directed bench for the M31 operand loader with a scoreboard of expected vector pairs.
module tb_m31_vector_operand_loader;

  localparam int unsigned N = 4;
  localparam logic [30:0] P = 31'h7FFF_FFFF;

  typedef struct {
    logic [30:0] a [N];
    logic [30:0] b [N];
  } pair_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [30:0] s_data = '0;
  logic        s_last = 1'b0;
  logic [30:0] vec1 [0:N-1];
  logic [30:0] vec2 [0:N-1];
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        framing_err;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  pair_t       exp_q [$];
  logic [30:0] words [$];
  bit          rand_done = 1'b0;
  bit          hold_prev = 1'b0;
  logic [30:0] snap1 [N];
  logic [30:0] snap2 [N];

  m31_vector_operand_loader #(.WORD_WIDTH(31), .VECTOR_SIZE(N)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .vec1(vec1), .vec2(vec2),
    .out_valid(out_valid), .out_ready(out_ready), .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Reference model: keep every accepted word; each 2N words form one expected pair.
  task automatic model_accept(input logic [30:0] d);
    pair_t p;
    words.push_back((d == P) ? 31'd0 : d);
    if (words.size() == 2 * N) begin
      for (int i = 0; i < N; i++) begin
        p.a[i] = words[i];
        p.b[i] = words[N + i];
      end
      exp_q.push_back(p);
      words.delete();
    end
  endtask

  task automatic send(input logic [30:0] d, input logic last);
    int unsigned n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 1000) begin
        check("send_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    model_accept(d);
  endtask

  task automatic drain();
    int unsigned n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b0;
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: compare on every output transfer, and enforce hold/stability while stalled.
  always @(negedge clk) begin
    pair_t p;
    bit ok;
    if (rst_n && !clear) begin
      if (hold_prev) begin
        ok = 1'b1;
        for (int i = 0; i < N; i++)
          if (vec1[i] !== snap1[i] || vec2[i] !== snap2[i]) ok = 1'b0;
        check("hold_valid", out_valid, 1'b1);
        check("hold_stable", ok, 1'b1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pair", 32'd1, 32'd0);
        end else begin
          p = exp_q.pop_front();
          ok = 1'b1;
          for (int i = 0; i < N; i++) begin
            if (vec1[i] !== p.a[i]) begin
              ok = 1'b0;
              $display("FAIL pair vec1[%0d]: got %h, expected %h", i, vec1[i], p.a[i]);
            end
            if (vec2[i] !== p.b[i]) begin
              ok = 1'b0;
              $display("FAIL pair vec2[%0d]: got %h, expected %h", i, vec2[i], p.b[i]);
            end
          end
          n_chk++;
          if (ok) n_pass++;
        end
      end
    end
    hold_prev = rst_n && !clear && out_valid && !out_ready;
    for (int i = 0; i < N; i++) begin
      snap1[i] = vec1[i];
      snap2[i] = vec2[i];
    end
  end

  initial begin
    logic [30:0] t2 [4];
    t2[0] = 31'h7FFF_FFFF; t2[1] = 31'h7FFF_FFFE; t2[2] = 31'd0; t2[3] = 31'd5;

    // Reset values
    #8;
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_ferr", framing_err, 1'b0);
    check("rst_vec1_0", vec1[0], 31'd0);
    check("rst_vec2_3", vec2[3], 31'd0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: stream 1..8 with no downstream acceptance
    for (int k = 1; k <= 8; k++) send(31'(k), k == 8);
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_s_ready", s_ready, 1'b0);
    for (int i = 0; i < N; i++) begin
      check("t1_vec1", vec1[i], 31'(i + 1));
      check("t1_vec2", vec2[i], 31'(i + 5));
    end
    s_valid = 1'b1; s_data = 31'd99;
    repeat (10) @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("t1_held_vec1_0", vec1[0], 31'd1);
    check("t1_held_vec2_3", vec2[3], 31'd8);
    check("t1_held_ferr", framing_err, 1'b0);
    drain();
    check("t1_s_ready_back", s_ready, 1'b1);

    // 2: canonicalisation of p, p-1 and 0
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) send(t2[k], (r == 1) && (k == 3));
    check("t2_vec1_0", vec1[0], 31'd0);
    check("t2_vec1_1", vec1[1], 31'h7FFF_FFFE);
    check("t2_ferr", framing_err, 1'b0);
    drain();

    // 4: early s_last marks a framing error but the load still completes
    for (int k = 1; k <= 8; k++) begin
      send(31'(20 + k), (k == 3) || (k == 8));
      if (k == 2) check("t4_ferr_before", framing_err, 1'b0);
      if (k == 3) check("t4_ferr_after", framing_err, 1'b1);
    end
    check("t4_full", out_valid, 1'b1);
    drain();
    check("t4_ferr_sticky", framing_err, 1'b1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("t4_ferr_cleared", framing_err, 1'b0);

    // Missing s_last on the final word also flags
    for (int k = 1; k <= 8; k++) send(31'(40 + k), 1'b0);
    check("t4_missing_last", framing_err, 1'b1);
    check("t4_missing_full", out_valid, 1'b1);
    drain();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;

    // 5: clear together with the 6th transfer drops that word and the partial load
    for (int k = 1; k <= 5; k++) send(31'(60 + k), 1'b0);
    s_valid = 1'b1; s_data = 31'd66; clear = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; clear = 1'b0;
    words.delete();
    check("t5_s_ready", s_ready, 1'b1);
    check("t5_out_valid", out_valid, 1'b0);
    send(31'd100, 1'b0);
    check("t5_vec1_0", vec1[0], 31'd100);
    for (int k = 1; k < 8; k++) send(31'(100 + k), k == 7);
    drain();

    // 6: asynchronous reset in LOAD_B
    for (int k = 1; k <= 6; k++) send(31'(200 + k), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_s_ready", s_ready, 1'b1);
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_vec1_0", vec1[0], 31'd0);
    check("t6_vec2_0", vec2[0], 31'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    words.delete();
    for (int k = 1; k <= 8; k++) send(31'(300 + k), k == 8);
    drain();

    // 3: random gaps and random backpressure
    fork
      begin
        for (int pr = 0; pr < 100; pr++)
          for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            send(($urandom_range(0, 5) == 0) ? P : 31'($urandom()), k == 7);
          end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();
    check("t3_ferr", framing_err, 1'b0);
    check("t3_no_partial", words.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/m31_vector_operand_loader.md
Name: m31_vector_operand_loader

Overview:
- Sequential front end for the element-wise M31 vector adder (modulus p = 2^31-1).
- Accepts a serial stream of M31 words via valid/ready and assembles two VECTOR_SIZE-element operand vectors, vec1 then vec2.
- Canonicalises each word and holds both vectors stable with out_valid until the downstream stage accepts them.
- Output arrays connect directly to the adder's vec1/vec2 inputs.

Parameters:
- WORD_WIDTH, 31, element width in bits; fixed to the M31 field width.
- VECTOR_SIZE, 16, elements per vector; legal range is 1 or more.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- clear  in  1  synchronous abort: discards any partial load.
- s_valid  in  1  input word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  WORD_WIDTH  input element.
- s_last  in  1  sender marks the final word of a pair (word 2*VECTOR_SIZE-1).
- vec1  out  WORD_WIDTH x [0:VECTOR_SIZE-1]  first operand vector.
- vec2  out  WORD_WIDTH x [0:VECTOR_SIZE-1]  second operand vector.
- out_valid  out  1  vec1/vec2 complete and stable.
- out_ready  in  1  downstream accepts the vector pair.
- framing_err  out  1  sticky flag: s_last mismatch detected.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset values:
  - State is LOAD_A; index is 0.
  - s_ready = 1, out_valid = 0, framing_err = 0.
  - All vec1/vec2 elements = 0.
- Index counter: width $clog2(VECTOR_SIZE) with a minimum of 1 bit.
- Input transfer occurs on s_valid & s_ready.
- Output transfer occurs on out_valid & out_ready.
- Canonicalisation: a word equal to 2^31-1 (≡ 0 mod p) is stored as 0. All other values are stored unchanged. Input is never otherwise reduced.
- FSM states: LOAD_A, LOAD_B, FULL.
- LOAD_A:
  - s_ready = 1.
  - On each transfer, vec1[idx] <= canon(s_data) and idx increments.
  - On the transfer with idx = VECTOR_SIZE-1: idx <= 0 and state goes to LOAD_B.
- LOAD_B:
  - Same as LOAD_A, writing into vec2.
  - On the final transfer, state goes to FULL.
  - out_valid rises in the cycle after the final input transfer (latency 1 clock).
- FULL:
  - s_ready = 0 and out_valid = 1.
  - vec1/vec2 must not change.
  - On an output transfer: state goes to LOAD_A with idx = 0. s_ready becomes 1 in the following cycle; there is no same-cycle bypass.
- s_ready and out_valid are registered, derived from state only. They are never combinational on s_valid or out_ready.
- Framing check (evaluated only on an input transfer):
  - s_last = 1 on any word other than the last word of vec2: framing_err <= 1. That word is stored normally and loading continues.
  - s_last = 0 on the last word of vec2: framing_err <= 1. Transition to FULL still occurs.
- framing_err clears only on reset or clear.
- clear:
  - Takes effect in any state: state <= LOAD_A, idx <= 0, framing_err <= 0.
  - Vector contents are left unchanged.
  - clear has priority over a simultaneous input or output transfer in the same cycle; that transfer is dropped.
- s_valid = 1 while in FULL: the word is not consumed. The sender holds it per valid/ready rules.
- VECTOR_SIZE = 1: LOAD_A and LOAD_B each take exactly one transfer.
- Asynchronous reset mid-load or in FULL returns all state to its reset values immediately, independent of clk.

Decomposition:
- Shared package m31_pkg:
  - M31_P = 31'h7FFF_FFFF.
  - M31_WIDTH = 31.
  - typedef m31_t = logic [30:0].
  - function m31_canon(m31_t) returning 0 for p and the input otherwise.
  - loader state enum {LOAD_A, LOAD_B, FULL}.
- No sub-module needed. The FSM, index counter and two register arrays fit one module, with canonicalisation done via the package function.

Test Plan:
1. VECTOR_SIZE=4, stream 1..8 (s_last on word 8), out_ready=0 → after word 8: out_valid=1, vec1={1,2,3,4}, vec2={5,6,7,8}, s_ready=0; values held 10 cycles.
2. Stream words 0x7FFFFFFF, 0x7FFFFFFE, 0, 5 (twice) → vec1={0,0x7FFFFFFE,0,5}; no framing_err.
3. Random s_valid gaps and out_ready backpressure over 100 pairs → every captured pair matches the scoreboard; no word lost or duplicated; out_valid never drops before out_ready.
4. s_last asserted on word 3 of 8 → framing_err=1 from the next cycle; load still completes at word 8. clear → framing_err=0 and idx=0.
5. clear asserted on the same cycle as the 6th input transfer → word dropped; next accepted word is written to vec1[0].
6. rst_n pulsed low mid-LOAD_B → outputs immediately at reset values; a fresh 8-word load then succeeds.
